ecc_bank_responder: RTL and testbench
=====================================

ECC_BANK_RESPONDER -- requirements
Module: ecc_bank_responder

Interface
REQ-001 SHALL have parameter NumWords, 256: number of storage words.
REQ-002 SHALL have parameter DataWidth, 32: payload bits per word, multiple of 8.
REQ-003 SHALL have parameter ProtWidth, 7: Hsiao check bits per word.
REQ-004 SHALL have parameter AddrWidth, 8: address width; elaboration check NumWords == 2**AddrWidth.
REQ-005 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  1  request valid; held stable with all request fields until gnt_o.
REQ-008 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-009 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port add_i  input  AddrWidth  word address.
REQ-011 SHALL have port be_i  input  DataWidth/8  byte enables for writes.
REQ-012 SHALL have port wdata_i  input  DataWidth  write payload.
REQ-013 SHALL have port inj_flip_i  input  DataWidth+ProtWidth  test mask XORed into codeword on every array write.
REQ-014 SHALL have port rvalid_o  output  1  read data valid.
REQ-015 SHALL have port rdata_o  output  DataWidth  corrected read payload.
REQ-016 SHALL have port bit_corrected_o  output  1  single-bit error corrected (one-cycle pulse).
REQ-017 SHALL have port uncorrectable_o  output  1  double-bit error detected (one-cycle pulse).

Function
REQ-018 SHALL store NumWords codewords of DataWidth+ProtWidth bits; array contents not reset.
REQ-019 SHALL implement FSM states Idle and Rmw.
REQ-020 Idle, req_i & ~we_i: gnt_o=1 combinationally; next cycle rvalid_o=1, rdata_o = decoded/corrected word, flags reflect decoder err.
REQ-021 Idle, req_i & we_i & be_i all-ones: gnt_o=1 same cycle; encode wdata_i, write codeword^inj_flip_i on that edge; no rvalid_o.
REQ-022 Idle, req_i & we_i & be_i == 0: gnt_o=1, array unchanged, no flags.
REQ-023 Idle, req_i & we_i & partial be_i: gnt_o=0; register stored codeword; go to Rmw.
REQ-024 Rmw: decode registered word, merge enabled bytes of wdata_i, re-encode, write codeword^inj_flip_i, gnt_o=1, return to Idle; pulse bit_corrected_o/uncorrectable_o per decode of old word.
REQ-025 Uncorrectable old word in Rmw SHALL still be written (merged with raw data bits) and flagged.
REQ-026 Back-to-back reads SHALL sustain one per cycle; partial writes SHALL occupy two cycles.
REQ-027 Read in cycle after a write to same address SHALL return the newly written data.
REQ-028 Reads SHALL NOT write back corrected data (scrubbing is external).
REQ-029 rdata_o SHALL hold last value when rvalid_o=0.

Reset
REQ-030 On rst_ni low: state Idle, rvalid_o=0, rdata_o=0, bit_corrected_o=0, uncorrectable_o=0.
REQ-031 Reset asserted in Rmw SHALL abort; no array write occurs.

Structure
REQ-032 Codeword width constant and FSM state enum SHALL reside in the shared ECC package.
REQ-033 SHALL instantiate existing hsiao_ecc_enc and hsiao_ecc_cor; no new sub-module.

Verification
REQ-034 Full write 0xDEADBEEF to addr 5, inj 0, read addr 5 -> gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF, flags 0.
REQ-035 Write 0x12345678 addr 9 with inj bit 3 set, read -> rdata 0x12345678, bit_corrected_o pulse with rvalid.
REQ-036 Write addr 9 with inj bits 3 and 10 set, read -> uncorrectable_o pulse, bit_corrected_o 0.
REQ-037 Addr 2 holds 0x11223344; write be 0b0010 data 0x0000AA00 -> gnt one cycle late; read returns 0x1122AA44.
REQ-038 Partial write pending, rst_ni pulsed in Rmw -> state Idle, outputs 0, addr word unchanged on read.
REQ-039 Reads to addr 0..255 every cycle, then addr 255 write/read -> one rvalid per cycle, correct data at wrap boundary.

Source files
------------

// File: rtl/ecc_bank_responder_pkg.sv
// Shared ECC definitions: codeword sizing, responder FSM states and the
// Hsiao column generator used by both the encoder and the corrector.
package ecc_bank_responder_pkg;

   localparam int unsigned DataWidthDefault = 32;
   localparam int unsigned ProtWidthDefault = 7;
   localparam int unsigned CodeWidth        = DataWidthDefault + ProtWidthDefault;

   typedef enum logic {
      Idle,
      Rmw
   } state_e;

   // Data column idx of the H matrix: distinct odd-weight (>=3) vectors, so
   // any single-bit error yields an odd syndrome and any double an even one.
   function automatic logic [15:0] hsiao_col(int idx, int pw);
      logic [15:0] col;
      int          cnt;
      col = '0;
      cnt = 0;
      for (int w = 3; w <= pw; w += 2) begin
         for (int v = 1; v < (1 << pw); v++) begin
            if ($countones(v) == w) begin
               if (cnt == idx) col = 16'(v);
               cnt++;
            end
         end
      end
      return col;
   endfunction

   function automatic logic [63:0] hsiao_row(int row, int dw, int pw);
      logic [63:0] mask;
      logic [15:0] col;
      mask = '0;
      for (int i = 0; i < dw; i++) begin
         col     = hsiao_col(i, pw);
         mask[i] = col[row];
      end
      return mask;
   endfunction

endpackage

// File: rtl/hsiao_ecc_cor.sv
// Hsiao SEC-DED corrector; err_o[0] = single error fixed, err_o[1] = uncorrectable.
module hsiao_ecc_cor
   import ecc_bank_responder_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ProtWidth = 7
) (
   input  logic [DataWidth+ProtWidth-1:0] cw_i,
   output logic [DataWidth-1:0]           data_o,
   output logic [1:0]                     err_o
);

   logic [DataWidth-1:0] data_raw;
   logic [ProtWidth-1:0] check_raw;
   logic [ProtWidth-1:0] syndrome;
   logic [DataWidth-1:0] flip;
   logic                 check_hit;
   logic                 single;

   assign data_raw  = cw_i[DataWidth-1:0];
   assign check_raw = cw_i[DataWidth+ProtWidth-1:DataWidth];

   for (genvar j = 0; j < ProtWidth; j++) begin : g_syn
      localparam logic [63:0] RowMask = hsiao_row(j, DataWidth, ProtWidth);
      assign syndrome[j] = ^(data_raw & RowMask[DataWidth-1:0]) ^ check_raw[j];
   end

   for (genvar i = 0; i < DataWidth; i++) begin : g_flip
      localparam logic [15:0] Col = hsiao_col(i, ProtWidth);
      assign flip[i] = (syndrome == Col[ProtWidth-1:0]);
   end

   // A weight-one syndrome means only a check bit flipped; data is intact.
   assign check_hit = (syndrome != '0) && ((syndrome & (syndrome - 1'b1)) == '0);
   assign single    = (|flip) | check_hit;
   assign data_o    = data_raw ^ flip;
   assign err_o     = {(syndrome != '0) & ~single, single};

endmodule

// File: rtl/hsiao_ecc_enc.sv
// Hsiao SEC-DED encoder; codeword layout is {check bits, data bits}.
module hsiao_ecc_enc
   import ecc_bank_responder_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ProtWidth = 7
) (
   input  logic [DataWidth-1:0]           data_i,
   output logic [DataWidth+ProtWidth-1:0] cw_o
);

   logic [ProtWidth-1:0] check;

   for (genvar j = 0; j < ProtWidth; j++) begin : g_check
      localparam logic [63:0] RowMask = hsiao_row(j, DataWidth, ProtWidth);
      assign check[j] = ^(data_i & RowMask[DataWidth-1:0]);
   end

   assign cw_o = {check, data_i};

endmodule

// File: rtl/ecc_bank_responder.sv
// ECC-protected single-port word bank; partial-byte writes take a
// read-modify-write pass so the stored codeword stays consistent.
module ecc_bank_responder
   import ecc_bank_responder_pkg::*;
#(
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = DataWidthDefault,
   parameter int unsigned ProtWidth = ProtWidthDefault,
   parameter int unsigned AddrWidth = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           req_i,
   output logic                           gnt_o,
   input  logic                           we_i,
   input  logic [AddrWidth-1:0]           add_i,
   input  logic [DataWidth/8-1:0]         be_i,
   input  logic [DataWidth-1:0]           wdata_i,
   input  logic [DataWidth+ProtWidth-1:0] inj_flip_i,
   output logic                           rvalid_o,
   output logic [DataWidth-1:0]           rdata_o,
   output logic                           bit_corrected_o,
   output logic                           uncorrectable_o
);

   localparam int unsigned CwWidth  = DataWidth + ProtWidth;
   localparam int unsigned NumBytes = DataWidth / 8;

   if (NumWords != 2 ** AddrWidth) begin : g_bad_num_words
      $error("NumWords must equal 2**AddrWidth");
   end
   if (DataWidth % 8 != 0) begin : g_bad_data_width
      $error("DataWidth must be a multiple of 8");
   end

   logic [CwWidth-1:0]   mem_q [NumWords];
   state_e               state_q;
   logic [CwWidth-1:0]   rmw_word_q;
   logic [CwWidth-1:0]   rd_word;
   logic [CwWidth-1:0]   dec_in;
   logic [CwWidth-1:0]   enc_out;
   logic [DataWidth-1:0] dec_data;
   logic [DataWidth-1:0] merged;
   logic [DataWidth-1:0] enc_data;
   logic [1:0]           dec_err;
   logic                 in_idle;
   logic                 full_be;
   logic                 zero_be;
   logic                 is_read;
   logic                 is_full_wr;
   logic                 is_partial;
   logic                 mem_we;

   assign in_idle    = (state_q == Idle);
   assign full_be    = &be_i;
   assign zero_be    = ~|be_i;
   assign is_read    = in_idle & req_i & ~we_i;
   assign is_full_wr = in_idle & req_i & we_i & full_be;
   assign is_partial = in_idle & req_i & we_i & ~full_be & ~zero_be;
   assign gnt_o      = (in_idle & req_i & (~we_i | full_be | zero_be)) | (state_q == Rmw);
   assign mem_we     = is_full_wr | (state_q == Rmw);

   assign rd_word  = mem_q[add_i];
   assign dec_in   = (state_q == Rmw) ? rmw_word_q : rd_word;
   assign enc_data = (state_q == Rmw) ? merged : wdata_i;

   // Uncorrectable words come out of the corrector unmodified, so the merge
   // naturally keeps their raw data bits in the unenabled lanes.
   always_comb begin
      merged = dec_data;
      for (int b = 0; b < NumBytes; b++) begin
         if (be_i[b]) merged[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
   end

   hsiao_ecc_enc #(
      .DataWidth (DataWidth),
      .ProtWidth (ProtWidth)
   ) u_enc (
      .data_i (enc_data),
      .cw_o   (enc_out)
   );

   hsiao_ecc_cor #(
      .DataWidth (DataWidth),
      .ProtWidth (ProtWidth)
   ) u_cor (
      .cw_i   (dec_in),
      .data_o (dec_data),
      .err_o  (dec_err)
   );

   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[add_i] <= enc_out ^ inj_flip_i;
   end

   // Async reset drops state to Idle at once, so a pending RMW never writes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= Idle;
         rmw_word_q      <= '0;
         rvalid_o        <= 1'b0;
         rdata_o         <= '0;
         bit_corrected_o <= 1'b0;
         uncorrectable_o <= 1'b0;
      end else begin
         rvalid_o        <= 1'b0;
         bit_corrected_o <= 1'b0;
         uncorrectable_o <= 1'b0;
         unique case (state_q)
            Idle: begin
               if (is_read) begin
                  rvalid_o        <= 1'b1;
                  rdata_o         <= dec_data;
                  bit_corrected_o <= dec_err[0];
                  uncorrectable_o <= dec_err[1];
               end else if (is_partial) begin
                  rmw_word_q <= rd_word;
                  state_q    <= Rmw;
               end
            end
            Rmw: begin
               bit_corrected_o <= dec_err[0];
               uncorrectable_o <= dec_err[1];
               state_q         <= Idle;
            end
            default: state_q <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_bank_responder.sv
// Directed bench for ecc_bank_responder: vector table plus hand-written
// reset-abort and streaming sequences.
module tb_ecc_bank_responder;
   import ecc_bank_responder_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 req_i = 1'b0;
   logic                 gnt_o;
   logic                 we_i = 1'b0;
   logic [7:0]           add_i = '0;
   logic [3:0]           be_i = '0;
   logic [31:0]          wdata_i = '0;
   logic [CodeWidth-1:0] inj_flip_i = '0;
   logic                 rvalid_o;
   logic [31:0]          rdata_o;
   logic                 bit_corrected_o;
   logic                 uncorrectable_o;

   int checks = 0;
   int errors = 0;

   ecc_bank_responder #(
      .NumWords  (256),
      .DataWidth (32),
      .ProtWidth (7),
      .AddrWidth (8)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_i           (req_i),
      .gnt_o           (gnt_o),
      .we_i            (we_i),
      .add_i           (add_i),
      .be_i            (be_i),
      .wdata_i         (wdata_i),
      .inj_flip_i      (inj_flip_i),
      .rvalid_o        (rvalid_o),
      .rdata_o         (rdata_o),
      .bit_corrected_o (bit_corrected_o),
      .uncorrectable_o (uncorrectable_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic           we;
      logic [7:0]     addr;
      logic [3:0]     be;
      logic [31:0]    wdata;
      logic [38:0]    inj;
      int             exp_wait;
      logic           exp_rvalid;
      logic [31:0]    exp_rdata;
      logic           exp_corr;
      logic           exp_unc;
   } vec_t;

   vec_t vecs [18];
   int   waits;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one request and waits (bounded) for its grant; returns with req low.
   task automatic apply_stimulus(input logic we, input logic [7:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic [38:0] inj,
                                 output int nwait);
      logic got;
      got     = 1'b0;
      nwait   = 0;
      req_i   = 1'b1;
      we_i    = we;
      add_i   = addr;
      be_i    = be;
      wdata_i = wdata;
      inj_flip_i = inj;
      while (!got && nwait < 8) begin
         @(negedge clk_i);
         if (gnt_o) got = 1'b1;
         else begin
            nwait++;
            @(posedge clk_i);
            #1;
         end
      end
      if (!got) check_output("gnt_timeout", 64'd0, 64'd1);
      @(posedge clk_i);
      #1;
      req_i      = 1'b0;
      inj_flip_i = '0;
   endtask

   function automatic logic [31:0] pattern(input int i);
      logic [7:0] a;
      a = 8'(i);
      return {a, ~a, a ^ 8'h5A, a};
   endfunction

   initial begin : main
      logic [31:0] exp_d;

      vecs[0]  = '{1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 39'h0,          0, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'd5, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'd9, 4'hF, 32'h12345678, 39'h8,          0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'd9, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'h12345678, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'd9, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'h12345678, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'd9, 4'hF, 32'h12345678, 39'h408,        0, 1'b0, 32'h12345678, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'd9, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'h12345270, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 8'd7, 4'hF, 32'hCAFEF00D, 39'h100000000,  0, 1'b0, 32'h12345270, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'd7, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 8'd2, 4'hF, 32'h11223344, 39'h0,          0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'd2, 4'h2, 32'h0000AA00, 39'h0,          1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'd2, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'h1122AA44, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 8'd2, 4'h0, 32'hFFFFFFFF, 39'h0,          0, 1'b0, 32'h1122AA44, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 8'd2, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'h1122AA44, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 8'd7, 4'h1, 32'h000000EE, 39'h0,          1, 1'b0, 32'h1122AA44, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 8'd7, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'hCAFEF0EE, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 8'd9, 4'h8, 32'hAB000000, 39'h0,          1, 1'b0, 32'hCAFEF0EE, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 8'd9, 4'hF, 32'h0,        39'h0,          0, 1'b1, 32'hAB345270, 1'b0, 1'b0};

      // Reset values, checked both while held and just after release.
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_output("rst_rvalid", 64'(rvalid_o), 64'd0);
      check_output("rst_rdata", 64'(rdata_o), 64'd0);
      check_output("rst_corr", 64'(bit_corrected_o), 64'd0);
      check_output("rst_unc", 64'(uncorrectable_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_output("idle_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk_i);
      #1;

      for (int v = 0; v < 18; v++) begin
         apply_stimulus(vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, vecs[v].inj, waits);
         check_output($sformatf("v%0d_gnt_wait", v), 64'(waits), 64'(vecs[v].exp_wait));
         @(negedge clk_i);
         check_output($sformatf("v%0d_rvalid", v), 64'(rvalid_o), 64'(vecs[v].exp_rvalid));
         check_output($sformatf("v%0d_rdata", v), 64'(rdata_o), 64'(vecs[v].exp_rdata));
         check_output($sformatf("v%0d_corr", v), 64'(bit_corrected_o), 64'(vecs[v].exp_corr));
         check_output($sformatf("v%0d_unc", v), 64'(uncorrectable_o), 64'(vecs[v].exp_unc));
         @(posedge clk_i);
         #1;
      end

      // Reset while the RMW pass is pending must abort the write.
      apply_stimulus(1'b1, 8'd3, 4'hF, 32'h55667788, 39'h0, waits);
      apply_stimulus(1'b0, 8'd3, 4'hF, 32'h0, 39'h0, waits);
      @(negedge clk_i);
      check_output("pre_abort_rdata", 64'(rdata_o), 64'h55667788);
      @(posedge clk_i);
      #1;
      req_i = 1'b1; we_i = 1'b1; add_i = 8'd3; be_i = 4'h1; wdata_i = 32'h000000FF;
      @(negedge clk_i);
      check_output("abort_idle_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_output("abort_rmw_gnt", 64'(gnt_o), 64'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      check_output("abort_gnt", 64'(gnt_o), 64'd0);
      check_output("abort_rvalid", 64'(rvalid_o), 64'd0);
      check_output("abort_rdata", 64'(rdata_o), 64'd0);
      check_output("abort_flags", 64'({bit_corrected_o, uncorrectable_o}), 64'd0);
      req_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      apply_stimulus(1'b0, 8'd3, 4'hF, 32'h0, 39'h0, waits);
      @(negedge clk_i);
      check_output("abort_read_rvalid", 64'(rvalid_o), 64'd1);
      check_output("abort_read_rdata", 64'(rdata_o), 64'h55667788);
      check_output("abort_read_flags", 64'({bit_corrected_o, uncorrectable_o}), 64'd0);
      @(posedge clk_i);
      #1;

      // Fill every word back-to-back, then stream reads one per cycle.
      req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; inj_flip_i = '0;
      for (int i = 0; i < 256; i++) begin
         add_i   = 8'(i);
         wdata_i = pattern(i);
         @(negedge clk_i);
         if (!gnt_o) check_output($sformatf("fill%0d_gnt", i), 64'(gnt_o), 64'd1);
         @(posedge clk_i);
         #1;
      end
      we_i = 1'b0;
      for (int i = 0; i <= 256; i++) begin
         if (i < 256) add_i = 8'(i);
         else req_i = 1'b0;
         @(negedge clk_i);
         if (i < 256) check_output($sformatf("rd%0d_gnt", i), 64'(gnt_o), 64'd1);
         if (i > 0) begin
            exp_d = pattern(i - 1);
            check_output($sformatf("rd%0d_rvalid", i - 1), 64'(rvalid_o), 64'd1);
            check_output($sformatf("rd%0d_rdata", i - 1), 64'(rdata_o), 64'(exp_d));
         end
         @(posedge clk_i);
         #1;
      end
      @(negedge clk_i);
      check_output("stream_end_rvalid", 64'(rvalid_o), 64'd0);
      check_output("stream_end_hold", 64'(rdata_o), 64'(pattern(255)));
      @(posedge clk_i);
      #1;

      // Write then immediately read the top address.
      req_i = 1'b1; we_i = 1'b1; add_i = 8'd255; be_i = 4'hF; wdata_i = 32'h0BADF00D;
      @(negedge clk_i);
      check_output("wrap_wr_gnt", 64'(gnt_o), 64'd1);
      @(posedge clk_i);
      #1;
      we_i = 1'b0;
      @(negedge clk_i);
      check_output("wrap_rd_gnt", 64'(gnt_o), 64'd1);
      check_output("wrap_wr_rvalid", 64'(rvalid_o), 64'd0);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      @(negedge clk_i);
      check_output("wrap_rd_rvalid", 64'(rvalid_o), 64'd1);
      check_output("wrap_rd_rdata", 64'(rdata_o), 64'h0BADF00D);
      check_output("wrap_rd_flags", 64'({bit_corrected_o, uncorrectable_o}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
